gpio_conv_ctrl: RTL and testbench
=================================

Name: gpio_conv_ctrl

Overview:
- Command sequencer between the MicroBlaze GPIO word and the 2D-convolution datapath.
- Decodes valid-strobed GPIO commands (kernel load, image length, column-memory load, result readout).
- Drives the kernel register, the image memory bank write port, conv start and result readback.
- Raises o_led when a frame's results are ready.

Parameters:
- N_MEM, 2: output column memories per frame; the input bank holds N_MEM+2 memories.
- ADDR_W, 10: memory address width; maximum image length is 2^ADDR_W-1.
- SEL_W, 2: memory-select width; must satisfy 2^SEL_W >= N_MEM+2.
- DATA_W, 24: GPIO data / memory write width.
- RES_W, 13: convolution result width.

Ports:
- i_CLK  in  1  system clock
- i_RST_n  in  1  asynchronous active-low reset
- i_GPIOdata  in  DATA_W  command payload
- i_GPIOctrl  in  3  command code: 000 kernel, 001 length, 010 load, 100 load-last, 011 read
- i_GPIOvalid  in  1  asynchronous, level-held handshake from GPIO
- o_kernel_we  out  1  kernel row write strobe
- o_kernel_idx  out  2  kernel row 0..2
- o_kernel_data  out  DATA_W  kernel row (3x8-bit coefficients)
- o_img_len  out  ADDR_W  configured image length L
- o_mem_we  out  1  image memory write strobe
- o_mem_sel  out  SEL_W  target memory 0..N_MEM+1
- o_mem_addr  out  ADDR_W  write address
- o_mem_data  out  DATA_W  write data
- o_conv_start  out  1  one-cycle run pulse
- i_conv_done  in  1  one-cycle datapath completion pulse
- o_rd_sel  out  SEL_W  result memory 0..N_MEM-1
- o_rd_addr  out  ADDR_W  result address
- i_rd_data  in  RES_W  result, valid 1 cycle after o_rd_addr
- o_GPIOdata  out  RES_W  current result to GPIO
- o_led  out  1  frame done / results readable
- o_err  out  1  sticky illegal-command flag

Behaviour:
- Reset: all outputs are 0. State is IDLE. The kernel row counter, write pointer wsel, first-frame flag (=1) and o_img_len are all cleared.
- Handshake:
  - i_GPIOvalid passes through a 2-FF synchronizer and a rising-edge detector, giving a one-cycle strobe `stb`.
  - i_GPIOctrl and i_GPIOdata are sampled on `stb`.
  - Strobe-to-write-strobe latency is 1 clock after `stb`.
  - Held valid levels produce exactly one `stb`.
- States: IDLE, LOAD, RUN, READ.
- IDLE, ctrl 000:
  - Pulse o_kernel_we with o_kernel_idx = kernel counter, then increment the counter modulo 3.
- IDLE, ctrl 001:
  - o_img_len <= data[ADDR_W-1:0].
  - If the value is < 3, o_img_len is unchanged and o_err is set.
  - The ctrl 000 and ctrl 001 commands reset the load address and the memory count.
- IDLE/LOAD, ctrl 010:
  - Write the word to (wsel, addr) and enter LOAD.
  - addr increments. After addr == L, addr wraps to 0, wsel increments modulo N_MEM+2, and the filled count increments.
  - Number of memories to fill: N_MEM+2 on the first frame, N_MEM afterwards.
  - wsel is never cleared except by reset; this rotates the bank.
- LOAD, ctrl 100:
  - Write the word as above.
  - If the write completes the required memory count, pulse o_conv_start 1 clock later and enter RUN.
  - Otherwise set o_err and stay in LOAD.
- RUN:
  - Ignore `stb`.
  - On i_conv_done: o_led <= 1, clear the first-frame flag, enter READ with o_rd_sel = 0 and o_rd_addr = 0.
  - i_conv_done in any other state is ignored.
- READ:
  - o_GPIOdata registers i_rd_data (address-to-o_GPIOdata latency is 2 clocks).
  - Each ctrl 011 `stb` advances o_rd_addr. After o_rd_addr == L-2, o_rd_addr wraps to 0 and o_rd_sel increments.
  - The `stb` that advances past (N_MEM-1, L-2) clears o_led and returns to IDLE. Total results read: N_MEM*(L-1).
- Illegal commands (wrong code for the state, or ctrl 1xx other than 100) are ignored and set o_err. o_err clears only on reset.
- Reset asserted mid-operation immediately returns everything to reset values; a partial load is discarded.

Test Plan:
- Kernel load: three 000 commands with 0x002000, 0x208020, 0x002000 -> o_kernel_we pulses with idx 0, 1, 2 and the matching data; a fourth 000 command -> idx 0.
- First frame with L=15, N_MEM=2:
  - 4x16 words loaded, the last with 100 -> writes go to sel 0..3, addr 0..15.
  - o_conv_start pulses once, 1 clock after the final write.
- Second frame:
  - 2x16 words loaded -> writes go to sel 0, 1 (wsel wrapped from 4).
  - Issuing 100 early, at word 20 -> o_err = 1, state stays LOAD.
- Readout: i_conv_done pulse -> o_led = 1; 28 ctrl-011 strobes -> addr sequence 0..13 on sel 0 then sel 1; o_led = 0 after the 28th strobe.
- Handshake: valid held high for 50 clocks -> exactly one write; valid toggled with ctrl 000 while in RUN -> no kernel write, o_err = 1.
- Reset: i_RST_n pulled low mid-LOAD -> all outputs 0 immediately; the next frame again loads N_MEM+2 memories starting at sel 0.

Source files
------------

// File: rtl/gpio_conv_ctrl.sv
// Command sequencer between the MicroBlaze GPIO word and the 2D-convolution datapath:
// kernel rows, image length, rotating input-bank loads, conv kick-off and result readout.
//
// state | meaning
// IDLE  | accepts kernel rows, image length, first load word
// LOAD  | filling the input bank, waiting for the load-last word
// RUN   | datapath busy, every command is rejected
// READ  | results readable, each read command advances the address
module gpio_conv_ctrl #(
    parameter int N_MEM  = 2,
    parameter int ADDR_W = 10,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 24,
    parameter int RES_W  = 13
) (
    input  logic              i_CLK,
    input  logic              i_RST_n,
    input  logic [DATA_W-1:0] i_GPIOdata,
    input  logic [2:0]        i_GPIOctrl,
    input  logic              i_GPIOvalid,
    output logic              o_kernel_we,
    output logic [1:0]        o_kernel_idx,
    output logic [DATA_W-1:0] o_kernel_data,
    output logic [ADDR_W-1:0] o_img_len,
    output logic              o_mem_we,
    output logic [SEL_W-1:0]  o_mem_sel,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_conv_start,
    input  logic              i_conv_done,
    output logic [SEL_W-1:0]  o_rd_sel,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [RES_W-1:0]  i_rd_data,
    output logic [RES_W-1:0]  o_GPIOdata,
    output logic              o_led,
    output logic              o_err
);

    localparam int N_BANK = N_MEM + 2;
    localparam int FILL_W = SEL_W + 1;
    localparam logic [FILL_W-1:0] NEED_FIRST = FILL_W'(N_BANK);
    localparam logic [FILL_W-1:0] NEED_NEXT  = FILL_W'(N_MEM);
    localparam logic [SEL_W-1:0]  LAST_BANK  = SEL_W'(N_BANK - 1);
    localparam logic [SEL_W-1:0]  LAST_RES   = SEL_W'(N_MEM - 1);

    localparam logic [2:0] CMD_KERNEL = 3'b000;
    localparam logic [2:0] CMD_LEN    = 3'b001;
    localparam logic [2:0] CMD_LOAD   = 3'b010;
    localparam logic [2:0] CMD_READ   = 3'b011;
    localparam logic [2:0] CMD_LAST   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_READ
    } state_t;

    state_t state, state_nxt;

    logic valid_s1, valid_s2, valid_s3;
    logic stb;

    logic [1:0]        kcnt, kcnt_nxt;
    logic [SEL_W-1:0]  wsel, wsel_nxt;
    logic [ADDR_W-1:0] waddr, waddr_nxt;
    logic [FILL_W-1:0] filled, filled_nxt;
    logic              first, first_nxt;
    logic              start_pend, start_pend_nxt;

    logic              kernel_we_nxt;
    logic [1:0]        kernel_idx_nxt;
    logic [DATA_W-1:0] kernel_data_nxt;
    logic [ADDR_W-1:0] img_len_nxt;
    logic              mem_we_nxt;
    logic [SEL_W-1:0]  mem_sel_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_data_nxt;
    logic              conv_start_nxt;
    logic [SEL_W-1:0]  rd_sel_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [RES_W-1:0]  gpio_nxt;
    logic              led_nxt;
    logic              err_nxt;

    logic              do_write;
    logic              frame_done;
    logic              clr_load;
    logic [FILL_W-1:0] need;
    logic              load_full;
    logic              rd_wrap;

    // valid is asynchronous to clk; only its synchronized rising edge is a command
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            valid_s3 <= 1'b0;
        end else begin
            valid_s1 <= i_GPIOvalid;
            valid_s2 <= valid_s1;
            valid_s3 <= valid_s2;
        end
    end

    assign stb = valid_s2 & ~valid_s3;

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state         <= S_IDLE;
            kcnt          <= '0;
            wsel          <= '0;
            waddr         <= '0;
            filled        <= '0;
            first         <= 1'b1;
            start_pend    <= 1'b0;
            o_kernel_we   <= 1'b0;
            o_kernel_idx  <= '0;
            o_kernel_data <= '0;
            o_img_len     <= '0;
            o_mem_we      <= 1'b0;
            o_mem_sel     <= '0;
            o_mem_addr    <= '0;
            o_mem_data    <= '0;
            o_conv_start  <= 1'b0;
            o_rd_sel      <= '0;
            o_rd_addr     <= '0;
            o_GPIOdata    <= '0;
            o_led         <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            state         <= state_nxt;
            kcnt          <= kcnt_nxt;
            wsel          <= wsel_nxt;
            waddr         <= waddr_nxt;
            filled        <= filled_nxt;
            first         <= first_nxt;
            start_pend    <= start_pend_nxt;
            o_kernel_we   <= kernel_we_nxt;
            o_kernel_idx  <= kernel_idx_nxt;
            o_kernel_data <= kernel_data_nxt;
            o_img_len     <= img_len_nxt;
            o_mem_we      <= mem_we_nxt;
            o_mem_sel     <= mem_sel_nxt;
            o_mem_addr    <= mem_addr_nxt;
            o_mem_data    <= mem_data_nxt;
            o_conv_start  <= conv_start_nxt;
            o_rd_sel      <= rd_sel_nxt;
            o_rd_addr     <= rd_addr_nxt;
            o_GPIOdata    <= gpio_nxt;
            o_led         <= led_nxt;
            o_err         <= err_nxt;
        end
    end

    assign need      = first ? NEED_FIRST : NEED_NEXT;
    assign load_full = (waddr == o_img_len) && ((filled + FILL_W'(1)) == need);
    assign rd_wrap   = (o_rd_addr == (o_img_len - ADDR_W'(2)));

    always_comb begin
        state_nxt       = state;
        kcnt_nxt        = kcnt;
        wsel_nxt        = wsel;
        waddr_nxt       = waddr;
        filled_nxt      = filled;
        first_nxt       = first;
        start_pend_nxt  = 1'b0;
        kernel_we_nxt   = 1'b0;
        kernel_idx_nxt  = o_kernel_idx;
        kernel_data_nxt = o_kernel_data;
        img_len_nxt     = o_img_len;
        mem_we_nxt      = 1'b0;
        mem_sel_nxt     = o_mem_sel;
        mem_addr_nxt    = o_mem_addr;
        mem_data_nxt    = o_mem_data;
        conv_start_nxt  = start_pend;
        rd_sel_nxt      = o_rd_sel;
        rd_addr_nxt     = o_rd_addr;
        gpio_nxt        = o_GPIOdata;
        led_nxt         = o_led;
        err_nxt         = o_err;
        do_write        = 1'b0;
        frame_done      = 1'b0;
        clr_load        = 1'b0;

        case (state)
            S_IDLE: begin
                if (stb) begin
                    case (i_GPIOctrl)
                        CMD_KERNEL: begin
                            kernel_we_nxt   = 1'b1;
                            kernel_idx_nxt  = kcnt;
                            kernel_data_nxt = i_GPIOdata;
                            kcnt_nxt        = (kcnt == 2'd2) ? 2'd0 : kcnt + 2'd1;
                            clr_load        = 1'b1;
                        end
                        CMD_LEN: begin
                            if (i_GPIOdata[ADDR_W-1:0] < ADDR_W'(3)) begin
                                err_nxt = 1'b1;
                            end else begin
                                img_len_nxt = i_GPIOdata[ADDR_W-1:0];
                            end
                            clr_load = 1'b1;
                        end
                        CMD_LOAD: begin
                            do_write  = 1'b1;
                            state_nxt = S_LOAD;
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                if (stb) begin
                    case (i_GPIOctrl)
                        CMD_LOAD: do_write = 1'b1;
                        CMD_LAST: begin
                            do_write = 1'b1;
                            if (load_full) begin
                                frame_done = 1'b1;
                                state_nxt  = S_RUN;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                if (stb) begin
                    err_nxt = 1'b1;
                end
                if (i_conv_done) begin
                    led_nxt     = 1'b1;
                    first_nxt   = 1'b0;
                    rd_sel_nxt  = '0;
                    rd_addr_nxt = '0;
                    state_nxt   = S_READ;
                end
            end
            S_READ: begin
                gpio_nxt = i_rd_data;
                if (stb) begin
                    if (i_GPIOctrl == CMD_READ) begin
                        if (rd_wrap) begin
                            rd_addr_nxt = '0;
                            if (o_rd_sel == LAST_RES) begin
                                rd_sel_nxt = '0;
                                led_nxt    = 1'b0;
                                state_nxt  = S_IDLE;
                            end else begin
                                rd_sel_nxt = o_rd_sel + SEL_W'(1);
                            end
                        end else begin
                            rd_addr_nxt = o_rd_addr + ADDR_W'(1);
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // wsel is never cleared outside reset so successive frames rotate through the bank
        if (do_write) begin
            mem_we_nxt   = 1'b1;
            mem_sel_nxt  = wsel;
            mem_addr_nxt = waddr;
            mem_data_nxt = i_GPIOdata;
            if (waddr == o_img_len) begin
                waddr_nxt  = '0;
                wsel_nxt   = (wsel == LAST_BANK) ? '0 : wsel + SEL_W'(1);
                filled_nxt = filled + FILL_W'(1);
            end else begin
                waddr_nxt = waddr + ADDR_W'(1);
            end
        end

        if (clr_load || frame_done) begin
            waddr_nxt  = '0;
            filled_nxt = '0;
        end

        start_pend_nxt = frame_done;
    end

endmodule

// File: tb/tb_gpio_conv_ctrl.sv
// Directed bench for gpio_conv_ctrl: a frame-level model predicts every write, kernel row,
// conv start and the readout levels; one compare process checks the DUT each cycle.
module tb_gpio_conv_ctrl;

    localparam int N_MEM  = 2;
    localparam int ADDR_W = 10;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 24;
    localparam int RES_W  = 13;
    localparam int N_BANK = N_MEM + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] gdata = '0;
    logic [2:0]        gctrl = '0;
    logic              gvalid = 1'b0;
    logic              conv_done = 1'b0;
    logic [RES_W-1:0]  rd_data = '0;

    logic              kernel_we;
    logic [1:0]        kernel_idx;
    logic [DATA_W-1:0] kernel_data;
    logic [ADDR_W-1:0] img_len;
    logic              mem_we;
    logic [SEL_W-1:0]  mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              conv_start;
    logic [SEL_W-1:0]  rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [RES_W-1:0]  gpio_out;
    logic              led;
    logic              err;

    gpio_conv_ctrl #(
        .N_MEM(N_MEM), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .DATA_W(DATA_W), .RES_W(RES_W)
    ) dut (
        .i_CLK(clk),
        .i_RST_n(rst_n),
        .i_GPIOdata(gdata),
        .i_GPIOctrl(gctrl),
        .i_GPIOvalid(gvalid),
        .o_kernel_we(kernel_we),
        .o_kernel_idx(kernel_idx),
        .o_kernel_data(kernel_data),
        .o_img_len(img_len),
        .o_mem_we(mem_we),
        .o_mem_sel(mem_sel),
        .o_mem_addr(mem_addr),
        .o_mem_data(mem_data),
        .o_conv_start(conv_start),
        .i_conv_done(conv_done),
        .o_rd_sel(rd_sel),
        .o_rd_addr(rd_addr),
        .i_rd_data(rd_data),
        .o_GPIOdata(gpio_out),
        .o_led(led),
        .o_err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] res_of(input int s, input int a);
        return RES_W'((s * 331 + a * 17 + 5) % 8192);
    endfunction

    function automatic logic [DATA_W-1:0] word_of(input int i);
        return DATA_W'((i * 4099 + 32'h1234) % 16777216);
    endfunction

    // result memory: data valid one cycle after the address
    always @(posedge clk) rd_data <= res_of(int'(rd_sel), int'(rd_addr));

    int total = 0;
    int bad   = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int sel; int addr; int data; bit start; } wr_t;
    typedef struct { int idx; int data; } kr_t;
    wr_t wq[$];
    kr_t kq[$];

    // frame-level model: modes 0 idle, 1 load, 2 run, 3 read
    int m_mode, m_k, m_base, m_nw, m_first, m_len, m_err, m_led, m_r, m_gpio;

    function automatic void model_reset();
        m_mode = 0; m_k = 0; m_base = 0; m_nw = 0; m_first = 1;
        m_len = 0; m_err = 0; m_led = 0; m_r = 0; m_gpio = 0;
    endfunction

    function automatic void model_write(input int d, input bit start);
        wr_t w;
        w.sel   = (m_base + m_nw / (m_len + 1)) % N_BANK;
        w.addr  = m_nw % (m_len + 1);
        w.data  = d;
        w.start = start;
        wq.push_back(w);
        m_nw++;
    endfunction

    function automatic void model_cmd(input logic [2:0] c, input logic [DATA_W-1:0] d);
        kr_t k;
        int need;
        need = (m_first != 0) ? N_BANK : N_MEM;
        case (m_mode)
            0: begin
                if (c == 3'b000) begin
                    k.idx = m_k; k.data = int'(d);
                    kq.push_back(k);
                    m_k = (m_k + 1) % 3;
                    m_nw = 0;
                end else if (c == 3'b001) begin
                    if (int'(d[ADDR_W-1:0]) < 3) m_err = 1;
                    else m_len = int'(d[ADDR_W-1:0]);
                    m_nw = 0;
                end else if (c == 3'b010) begin
                    model_write(int'(d), 1'b0);
                    m_mode = 1;
                end else begin
                    m_err = 1;
                end
            end
            1: begin
                if (c == 3'b010) begin
                    model_write(int'(d), 1'b0);
                end else if (c == 3'b100) begin
                    if (m_nw + 1 == need * (m_len + 1)) begin
                        model_write(int'(d), 1'b1);
                        m_mode = 2;
                        m_base = (m_base + need) % N_BANK;
                        m_nw = 0;
                    end else begin
                        model_write(int'(d), 1'b0);
                        m_err = 1;
                    end
                end else begin
                    m_err = 1;
                end
            end
            2: m_err = 1;
            default: begin
                if (c == 3'b011) begin
                    m_r++;
                    if (m_r == N_MEM * (m_len - 1)) begin
                        m_mode = 0; m_led = 0; m_r = 0;
                    end else begin
                        m_gpio = int'(res_of(m_r / (m_len - 1), m_r % (m_len - 1)));
                    end
                end else begin
                    m_err = 1;
                end
            end
        endcase
    endfunction

    function automatic void model_done();
        if (m_mode == 2) begin
            m_mode = 3; m_led = 1; m_first = 0; m_r = 0;
            m_gpio = int'(res_of(0, 0));
        end
    endfunction

    bit chk_en = 1'b0;
    bit quiet  = 1'b0;
    int n_kw = 0, n_mw = 0, n_start = 0;
    int last_sel = -1, last_addr = -1, last_kidx = -1;

    initial begin : compare
        bit start_due;
        wr_t w;
        kr_t k;
        int exp_sel, exp_addr;
        start_due = 1'b0;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                start_due = 1'b0;
            end else begin
                chk(conv_start == start_due, "conv_start", conv_start, start_due);
                if (conv_start) n_start++;
                start_due = 1'b0;
                if (kernel_we) begin
                    n_kw++;
                    last_kidx = int'(kernel_idx);
                    chk(kq.size() != 0, "kernel_we_unexpected", kq.size(), 1);
                    if (kq.size() != 0) begin
                        k = kq.pop_front();
                        chk(int'(kernel_idx) == k.idx, "kernel_idx", kernel_idx, k.idx);
                        chk(int'(kernel_data) == k.data, "kernel_data", kernel_data, k.data);
                    end
                end
                if (mem_we) begin
                    n_mw++;
                    last_sel  = int'(mem_sel);
                    last_addr = int'(mem_addr);
                    chk(wq.size() != 0, "mem_we_unexpected", wq.size(), 1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        chk(int'(mem_sel) == w.sel, "mem_sel", mem_sel, w.sel);
                        chk(int'(mem_addr) == w.addr, "mem_addr", mem_addr, w.addr);
                        chk(int'(mem_data) == w.data, "mem_data", mem_data, w.data);
                        start_due = w.start;
                    end
                end
                if (quiet) begin
                    exp_sel  = (m_mode == 3) ? m_r / (m_len - 1) : 0;
                    exp_addr = (m_mode == 3) ? m_r % (m_len - 1) : 0;
                    chk(int'(led) == m_led, "led", led, m_led);
                    chk(int'(err) == m_err, "err", err, m_err);
                    chk(int'(img_len) == m_len, "img_len", img_len, m_len);
                    chk(int'(rd_sel) == exp_sel, "rd_sel", rd_sel, exp_sel);
                    chk(int'(rd_addr) == exp_addr, "rd_addr", rd_addr, exp_addr);
                    chk(int'(gpio_out) == m_gpio, "gpio_data", gpio_out, m_gpio);
                end
            end
        end
    end

    task automatic cmd(input logic [2:0] c, input logic [DATA_W-1:0] d, input int hold = 6);
        model_cmd(c, d);
        quiet = 1'b0;
        @(negedge clk);
        gctrl = c; gdata = d; gvalid = 1'b1;
        repeat (hold) @(negedge clk);
        gvalid = 1'b0;
        repeat (4) @(negedge clk);
        chk(wq.size() + kq.size() == 0, "strobe_missing", wq.size() + kq.size(), 0);
        #1 quiet = 1'b1;
    endtask

    task automatic pulse_done();
        model_done();
        quiet = 1'b0;
        @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        repeat (4) @(negedge clk);
        #1 quiet = 1'b1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        quiet  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; gvalid = 1'b0; conv_done = 1'b0;
        #1;
        chk({kernel_we, mem_we, conv_start, led, err} == 5'b0, "rst_flags",
            {kernel_we, mem_we, conv_start, led, err}, 0);
        chk({kernel_idx, img_len, rd_sel, rd_addr} == '0, "rst_idx_len_rd",
            {kernel_idx, img_len, rd_sel, rd_addr}, 0);
        chk(kernel_data == '0, "rst_kernel_data", kernel_data, 0);
        chk({mem_sel, mem_addr} == '0, "rst_mem_sel_addr", {mem_sel, mem_addr}, 0);
        chk(mem_data == '0, "rst_mem_data", mem_data, 0);
        chk(gpio_out == '0, "rst_gpio_data", gpio_out, 0);
        model_reset();
        wq.delete();
        kq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_en = 1'b1;
        quiet  = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int kw0;
        model_reset();
        do_reset();

        cmd(3'b000, 24'h002000);
        cmd(3'b000, 24'h208020);
        cmd(3'b000, 24'h002000);
        cmd(3'b000, 24'h123456);
        chk(n_kw == 4, "kernel_count", n_kw, 4);
        chk(last_kidx == 0, "kernel_idx_wrap", last_kidx, 0);

        cmd(3'b001, 24'd15);
        chk(img_len == 10'd15, "img_len_15", img_len, 15);

        // first frame: 4 memories x 16 words, first word with valid held 50 clocks
        cmd(3'b010, word_of(0), 50);
        chk(n_mw == 1, "held_valid_one_write", n_mw, 1);
        for (int i = 1; i < 64; i++) cmd((i == 63) ? 3'b100 : 3'b010, word_of(i));
        chk(n_mw == 64, "frame1_writes", n_mw, 64);
        chk(n_start == 1, "frame1_start", n_start, 1);
        chk(last_sel == 3 && last_addr == 15, "frame1_last_loc", last_sel * 100 + last_addr, 315);

        pulse_done();
        chk(led == 1'b1, "led_after_done", led, 1);
        for (int i = 0; i < 28; i++) begin
            cmd(3'b011, '0);
            if (i == 13) chk(rd_sel == 2'd1 && rd_addr == 10'd0, "read_sel_wrap",
                             int'(rd_sel) * 100 + int'(rd_addr), 100);
        end
        chk(led == 1'b0, "led_after_28", led, 0);

        // second frame: 2 memories, premature load-last at word 20
        for (int i = 0; i < 32; i++) begin
            cmd((i == 19 || i == 31) ? 3'b100 : 3'b010, word_of(100 + i));
            if (i == 0) chk(last_sel == 0 && last_addr == 0, "frame2_first_loc",
                            last_sel * 100 + last_addr, 0);
            if (i == 19) chk(err == 1'b1, "early_last_err", err, 1);
        end
        chk(last_sel == 1 && last_addr == 15, "frame2_last_loc", last_sel * 100 + last_addr, 115);
        chk(n_start == 2, "frame2_start", n_start, 2);
        pulse_done();
        for (int i = 0; i < 28; i++) cmd(3'b011, '0);

        // partial load into sel 2, then reset mid-load
        for (int i = 0; i < 5; i++) cmd(3'b010, word_of(200 + i));
        do_reset();

        cmd(3'b001, 24'd4);
        for (int i = 0; i < 20; i++) begin
            cmd((i == 19) ? 3'b100 : 3'b010, word_of(300 + i));
            if (i == 0) chk(last_sel == 0 && last_addr == 0, "post_reset_first_loc",
                            last_sel * 100 + last_addr, 0);
        end
        chk(last_sel == 3 && last_addr == 4, "post_reset_last_loc", last_sel * 100 + last_addr, 304);

        kw0 = n_kw;
        cmd(3'b000, 24'hABCDEF);
        chk(n_kw == kw0, "run_no_kernel_we", n_kw, kw0);
        chk(err == 1'b1, "run_cmd_err", err, 1);

        pulse_done();
        for (int i = 0; i < 6; i++) cmd(3'b011, '0);
        chk(led == 1'b0, "led_after_6", led, 0);

        cmd(3'b001, 24'd2);
        chk(img_len == 10'd4, "len_2_rejected", img_len, 4);
        cmd(3'b001, 24'd3);
        chk(img_len == 10'd3, "len_3_accepted", img_len, 3);
        cmd(3'b111, 24'd0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
